// File: rtl/instr_loader.sv
// Byte-stream instruction loader: packs little-endian bytes into 32-bit words and
// writes them sequentially from BASE_ADDR, holding the CPU off via busy while loading.
module instr_loader #(
    parameter int                         DATA_WIDTH        = 8,
    parameter int                         ADDRESS_WIDTH     = 32,
    parameter int                         INSTRUCTION_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0]   BASE_ADDR         = 32'hBFC00000,
    parameter int                         DEPTH_BYTES       = 4096
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic                          in_valid,
    input  logic                          in_last,
    output logic                          in_ready,
    output logic                          mem_we,
    output logic [ADDRESS_WIDTH-1:0]      mem_addr,
    output logic [INSTRUCTION_WIDTH-1:0]  mem_wdata,
    output logic [ADDRESS_WIDTH-1:0]      word_count,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);

    localparam logic [ADDRESS_WIDTH-1:0] WORD_STEP = ADDRESS_WIDTH'(4);
    localparam logic [ADDRESS_WIDTH-1:0] END_ADDR  = BASE_ADDR + ADDRESS_WIDTH'(DEPTH_BYTES);
    // Address of the final word slot; the write address saturates here.
    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = END_ADDR - WORD_STEP;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_WRITE   = 3'd2,
        ST_DONE    = 3'd3,
        ST_ERROR   = 3'd4
    } state_t;

    state_t                         state_r;
    state_t                         state_next_s;
    logic                           launch_s;
    logic                           accept_s;
    logic                           word_end_s;
    logic [INSTRUCTION_WIDTH-1:0]   packed_s;

    logic [1:0]                     lane_r;
    logic [INSTRUCTION_WIDTH-1:0]   pack_r;
    logic                           last_seen_r;
    logic                           in_ready_r;
    logic                           busy_r;
    logic                           mem_we_r;
    logic                           done_r;
    logic                           err_r;
    logic [ADDRESS_WIDTH-1:0]       mem_addr_r;
    logic [INSTRUCTION_WIDTH-1:0]   mem_wdata_r;
    logic [ADDRESS_WIDTH-1:0]       word_count_r;

    // Next-state decode plus byte-accept and load-launch qualifiers.
    always_comb begin
        state_next_s = state_r;
        launch_s     = 1'b0;
        accept_s     = 1'b0;
        word_end_s   = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    launch_s     = 1'b1;
                    state_next_s = ST_COLLECT;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_COLLECT: begin
                accept_s   = in_valid && in_ready_r;
                word_end_s = accept_s && ((lane_r == 2'd3) || in_last);
                if (word_end_s) begin
                    state_next_s = ST_WRITE;
                end else begin
                    state_next_s = ST_COLLECT;
                end
            end
            ST_WRITE: begin
                // A final byte wins over a full region: the image fit exactly.
                if (last_seen_r) begin
                    state_next_s = ST_DONE;
                end else if (mem_addr_r == LAST_ADDR) begin
                    state_next_s = ST_ERROR;
                end else begin
                    state_next_s = ST_COLLECT;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Merge the incoming byte into its little-endian lane of the pack register.
    always_comb begin
        packed_s = pack_r;
        case (lane_r)
            2'd0:    packed_s[0*DATA_WIDTH +: DATA_WIDTH] = in_data;
            2'd1:    packed_s[1*DATA_WIDTH +: DATA_WIDTH] = in_data;
            2'd2:    packed_s[2*DATA_WIDTH +: DATA_WIDTH] = in_data;
            2'd3:    packed_s[3*DATA_WIDTH +: DATA_WIDTH] = in_data;
            default: packed_s = pack_r;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Status outputs registered from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_ready_r <= 1'b0;
            busy_r     <= 1'b0;
            mem_we_r   <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            in_ready_r <= (state_next_s == ST_COLLECT);
            busy_r     <= (state_next_s == ST_COLLECT) || (state_next_s == ST_WRITE);
            mem_we_r   <= (state_next_s == ST_WRITE);
            done_r     <= (state_next_s == ST_DONE);
            err_r      <= (state_next_s == ST_ERROR);
        end
    end

    // Packing, write address/data and word counting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lane_r       <= 2'd0;
            pack_r       <= {INSTRUCTION_WIDTH{1'b0}};
            last_seen_r  <= 1'b0;
            mem_addr_r   <= BASE_ADDR;
            mem_wdata_r  <= {INSTRUCTION_WIDTH{1'b0}};
            word_count_r <= {ADDRESS_WIDTH{1'b0}};
        end else if (launch_s) begin
            lane_r       <= 2'd0;
            pack_r       <= {INSTRUCTION_WIDTH{1'b0}};
            last_seen_r  <= 1'b0;
            mem_addr_r   <= BASE_ADDR;
            word_count_r <= {ADDRESS_WIDTH{1'b0}};
        end else if (accept_s) begin
            lane_r <= lane_r + 2'd1;
            pack_r <= packed_s;
            if (word_end_s) begin
                mem_wdata_r <= packed_s;
                last_seen_r <= in_last;
            end
        end else if (state_r == ST_WRITE) begin
            word_count_r <= word_count_r + ADDRESS_WIDTH'(1);
            lane_r       <= 2'd0;
            pack_r       <= {INSTRUCTION_WIDTH{1'b0}};
            if (mem_addr_r != LAST_ADDR) begin
                mem_addr_r <= mem_addr_r + WORD_STEP;
            end
        end
    end

    assign in_ready   = in_ready_r;
    assign busy       = busy_r;
    assign mem_we     = mem_we_r;
    assign done       = done_r;
    assign err        = err_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;
    assign word_count = word_count_r;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: a per-cycle behavioural model built from the
// handshake/packing rules, directed image tests, random streams and a small-region instance.
module tb_instr_loader;

    localparam logic [31:0] BASE  = 32'hBFC00000;
    localparam int          DEPTH = 4096;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_ready, mem_we, busy, done, err;
    logic [31:0] mem_addr, mem_wdata, word_count;

    logic        s_start = 1'b0;
    logic [7:0]  s_in_data = 8'h00;
    logic        s_in_valid = 1'b0;
    logic        s_in_last = 1'b0;
    logic        s_in_ready, s_mem_we, s_busy, s_done, s_err;
    logic [31:0] s_mem_addr, s_mem_wdata, s_word_count;

    int total = 0;
    int bad = 0;
    bit cmp_on = 1'b0;
    bit sim_end = 1'b0;
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    logic [31:0] s_log_addr[$];
    logic [31:0] s_log_data[$];
    logic [7:0]  img[$];

    instr_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .word_count(word_count), .busy(busy), .done(done), .err(err)
    );

    instr_loader #(.DEPTH_BYTES(8)) dut_small (
        .clk(clk), .rst_n(rst_n), .start(s_start), .in_data(s_in_data), .in_valid(s_in_valid),
        .in_last(s_in_last), .in_ready(s_in_ready), .mem_we(s_mem_we), .mem_addr(s_mem_addr),
        .mem_wdata(s_mem_wdata), .word_count(s_word_count), .busy(s_busy), .done(s_done),
        .err(s_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s actual=timeout required=event at %0t", name, $time);
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: tracks busy/done/err, accepted bytes and the word due next cycle.
    initial begin : model
        bit          m_busy, m_done, m_err, m_we, m_last, cur_busy, rdy, nwe;
        int          m_wc, m_cnt;
        logic [31:0] m_pack, m_addr, m_data;
        m_busy = 0; m_done = 0; m_err = 0; m_we = 0; m_last = 0;
        m_wc = 0; m_cnt = 0; m_pack = 32'h0; m_addr = BASE; m_data = 32'h0;
        wait (cmp_on);
        while (!sim_end) begin
            @(negedge clk);
            chk("mem_we", 32'(mem_we), 32'(m_we));
            if (m_we) begin
                chk("mem_addr", mem_addr, m_addr);
                chk("mem_wdata", mem_wdata, m_data);
                log_addr.push_back(mem_addr);
                log_data.push_back(mem_wdata);
            end
            chk("word_count", word_count, 32'(m_wc));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("in_ready", 32'(in_ready), 32'(m_busy && !m_we));
            chk("done", 32'(done), 32'(m_done));
            chk("err", 32'(err), 32'(m_err));
            cur_busy = m_busy;
            rdy = m_busy && !m_we;
            nwe = 1'b0;
            if (!rst_n) begin
                m_busy = 0; m_done = 0; m_err = 0; m_last = 0;
                m_wc = 0; m_cnt = 0; m_pack = 32'h0;
            end else begin
                if (m_we) begin
                    m_wc++;
                    m_cnt = 0;
                    m_pack = 32'h0;
                    if (m_last) begin
                        m_busy = 0; m_done = 1;
                    end else if (m_wc == DEPTH / 4) begin
                        m_busy = 0; m_err = 1;
                    end
                end else if (rdy && in_valid) begin
                    m_pack = m_pack | (32'(in_data) << (8 * m_cnt));
                    m_cnt++;
                    if (in_last || m_cnt == 4) begin
                        nwe = 1'b1;
                        m_addr = BASE + 32'(4 * m_wc);
                        m_data = m_pack;
                        m_last = in_last;
                    end
                end
                if (start && !cur_busy) begin
                    m_busy = 1; m_done = 0; m_err = 0;
                    m_wc = 0; m_cnt = 0; m_pack = 32'h0;
                end
            end
            m_we = nwe;
        end
    end

    always @(negedge clk) begin
        if (s_mem_we) begin
            s_log_addr.push_back(s_mem_addr);
            s_log_data.push_back(s_mem_wdata);
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        sync();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        int guard;
        guard = 0;
        in_data = b; in_valid = 1'b1; in_last = last;
        @(negedge clk);
        while (!in_ready && guard < 40) begin
            guard++;
            @(negedge clk);
        end
        if (!in_ready) timeout_fail("handshake");
        sync();
        in_valid = 1'b0; in_last = 1'b0; in_data = 8'($urandom);
    endtask

    task automatic s_send_byte(input logic [7:0] b, input logic last);
        int guard;
        guard = 0;
        s_in_data = b; s_in_valid = 1'b1; s_in_last = last;
        @(negedge clk);
        while (!s_in_ready && guard < 40) begin
            guard++;
            @(negedge clk);
        end
        if (!s_in_ready) timeout_fail("s_handshake");
        sync();
        s_in_valid = 1'b0; s_in_last = 1'b0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        @(negedge clk);
        while (busy && guard < 50) begin
            guard++;
            @(negedge clk);
        end
        if (busy) timeout_fail("wait_idle");
        sync();
    endtask

    // Start a load and stream img, last on the final byte; gaps may carry stray starts.
    task automatic load(input int gap_max, input bit stray);
        pulse_start();
        for (int i = 0; i < img.size(); i++) begin
            send_byte(img[i], (i == img.size() - 1));
            if (i != img.size() - 1) begin
                repeat ($urandom_range(gap_max, 0)) begin
                    if (stray && $urandom_range(3, 0) == 0) start = 1'b1;
                    sync();
                    start = 1'b0;
                end
            end
        end
        wait_idle();
    endtask

    initial begin : main
        logic [31:0] w;
        int n;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cmp_on = 1'b1;

        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_mem_addr", mem_addr, BASE);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_word_count", word_count, 32'h0);
        sync();

        img = '{8'h13, 8'h05, 8'h00, 8'h00};
        log_addr.delete(); log_data.delete();
        load(0, 1'b0);
        chk("t1_writes", 32'(log_addr.size()), 32'd1);
        if (log_addr.size() == 1) begin
            chk("t1_addr", log_addr[0], 32'hBFC00000);
            chk("t1_data", log_data[0], 32'h00000513);
        end
        chk("t1_done", 32'(done), 32'h1);
        chk("t1_wc", word_count, 32'd1);
        chk("t1_ready", 32'(in_ready), 32'h0);

        img = '{8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h20, 8'h00};
        log_addr.delete(); log_data.delete();
        load(0, 1'b0);
        chk("t2_writes", 32'(log_addr.size()), 32'd2);
        if (log_addr.size() == 2) begin
            chk("t2_addr0", log_addr[0], 32'hBFC00000);
            chk("t2_data0", log_data[0], 32'h00100093);
            chk("t2_addr1", log_addr[1], 32'hBFC00004);
            chk("t2_data1", log_data[1], 32'h00200113);
        end
        chk("t2_wc", word_count, 32'd2);

        img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        log_addr.delete(); log_data.delete();
        load(2, 1'b1);
        chk("t3_writes", 32'(log_addr.size()), 32'd2);
        if (log_addr.size() == 2) begin
            chk("t3_data0", log_data[0], 32'hDDCCBBAA);
            chk("t3_addr1", log_addr[1], 32'hBFC00004);
            chk("t3_data1", log_data[1], 32'h000000EE);
        end

        for (int k = 0; k < 8; k++) begin
            img.delete();
            n = $urandom_range(40, 1);
            for (int i = 0; i < n; i++) img.push_back(8'($urandom));
            log_addr.delete(); log_data.delete();
            load((k == 0) ? 0 : 3, 1'b1);
            chk("rnd_writes", 32'(log_addr.size()), 32'((n + 3) / 4));
            for (int i = 0; i < log_data.size(); i++) begin
                w = 32'h0;
                for (int j = 0; j < 4; j++)
                    if (4 * i + j < n) w = w | (32'(img[4 * i + j]) << (8 * j));
                chk("rnd_stream", log_data[i], w);
            end
        end

        // Reset after two accepted bytes of a load.
        log_addr.delete(); log_data.delete();
        pulse_start();
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        rst_n = 1'b0;
        sync();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst2_mem_we", 32'(mem_we), 32'h0);
        chk("rst2_mem_addr", mem_addr, BASE);
        chk("rst2_mem_wdata", mem_wdata, 32'h0);
        chk("rst2_wc", word_count, 32'h0);
        chk("rst2_busy", 32'(busy), 32'h0);
        sync();
        chk("rst2_no_write", 32'(log_addr.size()), 32'd0);
        img = '{8'h01, 8'h02, 8'h03, 8'h04};
        load(1, 1'b0);
        if (log_addr.size() == 1) begin
            chk("rst2_addr", log_addr[0], 32'hBFC00000);
            chk("rst2_data", log_data[0], 32'h04030201);
        end else begin
            chk("rst2_writes", 32'(log_addr.size()), 32'd1);
        end

        // Eight-byte region overflowed by an image without a final byte.
        s_start = 1'b1; sync(); s_start = 1'b0;
        for (int i = 0; i < 8; i++) s_send_byte(8'(8'h30 + i), 1'b0);
        s_in_data = 8'h38; s_in_valid = 1'b1;
        repeat (6) sync();
        @(negedge clk);
        chk("s_ready", 32'(s_in_ready), 32'h0);
        chk("s_err", 32'(s_err), 32'h1);
        chk("s_done", 32'(s_done), 32'h0);
        chk("s_busy", 32'(s_busy), 32'h0);
        chk("s_wc", s_word_count, 32'd2);
        chk("s_writes", 32'(s_log_addr.size()), 32'd2);
        if (s_log_addr.size() == 2) begin
            chk("s_addr0", s_log_addr[0], 32'hBFC00000);
            chk("s_data0", s_log_data[0], 32'h33323130);
            chk("s_addr1", s_log_addr[1], 32'hBFC00004);
        end
        sync();
        s_in_valid = 1'b0;
        s_start = 1'b1; sync(); s_start = 1'b0;
        @(negedge clk);
        chk("s_restart_err", 32'(s_err), 32'h0);
        chk("s_restart_addr", s_mem_addr, 32'hBFC00000);
        chk("s_restart_ready", 32'(s_in_ready), 32'h1);
        sync();
        for (int i = 0; i < 4; i++) s_send_byte(8'(8'h50 + i), (i == 3));
        repeat (2) sync();
        chk("s_done2", 32'(s_done), 32'h1);
        if (s_log_addr.size() == 3) begin
            chk("s_addr2", s_log_addr[2], 32'hBFC00000);
            chk("s_data2", s_log_data[2], 32'h53525150);
        end else begin
            chk("s_writes2", 32'(s_log_addr.size()), 32'd3);
        end

        sim_end = 1'b1;
        repeat (3) sync();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
